// File: rtl/mkio_rt_responder.sv
// MIL-STD-1553-style remote terminal responder: decodes command words, stores
// received data words into per-subaddress buffers, and answers with a status
// word (plus buffer data for transmit commands) after a fixed response pause.
// Ports: clk/reset (sync, active-low); start/rx_valid/rx_data/p_error from the
// channel controller; tx_data/tx_cd/tx_ready toward it, held off by tx_busy;
// busy flags an active message; host_* is an independent buffer access port.
module mkio_rt_responder #(
  parameter logic [4:0] ADDRESS      = 5'd1,
  parameter int         NUM_SA       = 4,
  parameter int         PAUSE_CYCLES = 8,
  parameter int         RX_TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [15:0]                 rx_data,
  input  logic                        rx_valid,
  input  logic                        p_error,
  input  logic                        tx_busy,
  output logic [15:0]                 tx_data,
  output logic                        tx_cd,
  output logic                        tx_ready,
  output logic                        busy,
  input  logic [$clog2(NUM_SA)+4:0]   host_addr,
  input  logic                        host_we,
  input  logic [15:0]                 host_wdata,
  output logic [15:0]                 host_rdata
);

  localparam int AW    = $clog2(NUM_SA) + 5;
  localparam int DEPTH = NUM_SA * 32;
  localparam int TMAX  = (PAUSE_CYCLES > RX_TIMEOUT) ? PAUSE_CYCLES : RX_TIMEOUT;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, DECODE, RX_DATA, PAUSE, SEND_OS, SEND_WAIT, SEND_DATA, DONE
  } state_t;

  state_t          state, state_next;
  logic            cmd_k, cmd_bcast, cmd_perr;
  logic [4:0]      cmd_sa, cmd_n, n_last;
  logic [4:0]      word_cnt;
  logic [TW-1:0]   timer;
  logic            msg_err;
  logic            start_acc, last_word, rt_we;
  logic [AW-1:0]   rt_idx;
  logic [15:0]     rd_word;
  logic [15:0]     mem [DEPTH];

  // Own address, or broadcast (31) only for receive commands.
  assign start_acc = start && ((rx_data[15:11] == ADDRESS) ||
                               (rx_data[15:11] == 5'd31 && !rx_data[10]));
  // Count field 0 encodes 32 words; the 5-bit wrap of N-1 gives 31 for that case.
  assign n_last    = cmd_n - 5'd1;
  assign last_word = (word_cnt == n_last);
  // {SA-1, word}; the low bits of the concatenation form the buffer index.
  assign rt_idx    = AW'({cmd_sa - 5'd1, word_cnt});
  // A same-cycle accepted start supersedes the data word.
  assign rt_we     = (state == RX_DATA) && rx_valid && !msg_err && !start_acc;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (start_acc) begin
      state_next = DECODE;
    end else begin
      case (state)
        IDLE:      state_next = IDLE;
        DECODE:    state_next = cmd_k ? PAUSE : RX_DATA;
        RX_DATA: begin
          if (rx_valid) begin
            if (last_word) state_next = PAUSE;
          end else if (timer == TW'(RX_TIMEOUT - 1)) begin
            state_next = IDLE;
          end
        end
        PAUSE:     if (timer == TW'(PAUSE_CYCLES - 1))
                     state_next = cmd_bcast ? DONE : SEND_OS;
        SEND_OS:   if (!tx_busy)
                     state_next = (cmd_k && !msg_err) ? SEND_WAIT : DONE;
        SEND_WAIT: if (!tx_busy) state_next = SEND_DATA;
        SEND_DATA: if (!tx_busy) state_next = last_word ? DONE : SEND_WAIT;
        DONE:      state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Outputs: words are presented only when the controller is free, so a
  // stalled SEND_OS/SEND_DATA simply holds until tx_busy drops.
  always_comb begin
    tx_data  = 16'd0;
    tx_cd    = 1'b0;
    tx_ready = 1'b0;
    busy     = (state != IDLE) && (state != DONE);
    case (state)
      SEND_OS: begin
        tx_data  = {ADDRESS, msg_err, 10'd0};
        tx_cd    = 1'b1;
        tx_ready = !tx_busy;
      end
      SEND_DATA: begin
        tx_data  = rd_word;
        tx_ready = !tx_busy;
      end
      default: ;
    endcase
  end

  // Message datapath: command fields, error flag, word counter, timer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd_k     <= 1'b0;
      cmd_bcast <= 1'b0;
      cmd_perr  <= 1'b0;
      cmd_sa    <= 5'd0;
      cmd_n     <= 5'd0;
      msg_err   <= 1'b0;
      word_cnt  <= 5'd0;
      timer     <= '0;
    end else if (start_acc) begin
      cmd_k     <= rx_data[10];
      cmd_bcast <= (rx_data[15:11] == 5'd31);
      cmd_perr  <= p_error;
      cmd_sa    <= rx_data[9:5];
      cmd_n     <= rx_data[4:0];
      word_cnt  <= 5'd0;
      timer     <= '0;
    end else begin
      case (state)
        DECODE: begin
          msg_err  <= cmd_perr || (cmd_sa == 5'd0) || (cmd_sa == 5'd31) ||
                      (int'(cmd_sa) > NUM_SA);
          word_cnt <= 5'd0;
          timer    <= '0;
        end
        RX_DATA: begin
          if (rx_valid) begin
            msg_err  <= msg_err | p_error;
            word_cnt <= word_cnt + 5'd1;
            timer    <= '0;
          end else begin
            timer    <= timer + TW'(1);
          end
        end
        PAUSE:     timer <= (state_next == PAUSE) ? timer + TW'(1) : '0;
        SEND_DATA: if (!tx_busy) word_cnt <= word_cnt + 5'd1;
        default:   timer <= '0;
      endcase
    end
  end

  // Buffer: not reset. RT receive write wins a same-index collision; reads
  // return the pre-write contents.
  always_ff @(posedge clk) begin
    if (host_we && !(rt_we && (rt_idx == host_addr)))
      mem[host_addr] <= host_wdata;
    if (rt_we)
      mem[rt_idx] <= rx_data;
    host_rdata <= mem[host_addr];
    if (state == SEND_WAIT)
      rd_word <= mem[rt_idx];
  end

endmodule

// File: doc/mkio_rt_responder.md
MKIO_RT_RESPONDER -- requirements
Module: mkio_rt_responder

Interface
REQ-001 SHALL have parameter ADDRESS, default 5'd1, own terminal address.
REQ-002 SHALL have parameter NUM_SA, default 4, number of data subaddresses (1..30), each with 32 x 16-bit buffer.
REQ-003 SHALL have parameter PAUSE_CYCLES, default 8, clk cycles from last received word to status word.
REQ-004 SHALL have parameter RX_TIMEOUT, default 64, max clk cycles allowed between consecutive received data words.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; rx_data holds a command word.
REQ-008 rx_data  in  16  command/data word from channel controller.
REQ-009 rx_valid  in  1  one-cycle pulse; rx_data holds a data word.
REQ-010 p_error  in  1  parity error on the word qualified by start/rx_valid.
REQ-011 tx_busy  in  1  channel controller still transmitting previous word.
REQ-012 tx_data  out  16  word to transmit.
REQ-013 tx_cd  out  1  1 = status (command sync), 0 = data sync.
REQ-014 tx_ready  out  1  one-cycle pulse; tx_data/tx_cd valid.
REQ-015 busy  out  1  high while a message is being processed.
REQ-016 host_addr  in  $clog2(NUM_SA)+5  host buffer address {bank, word}.
REQ-017 host_we / host_wdata  in  1 / 16  host buffer write.
REQ-018 host_rdata  out  16  host read data, 1-cycle latency.

Function
REQ-019 Command decode SHALL use [15:11] address, [10] K (1 = transmit to controller), [9:5] subaddress SA, [4:0] count N (0 means 32).
REQ-020 start SHALL be ignored unless address == ADDRESS, or address == 31 with K == 0 (broadcast receive).
REQ-021 States SHALL be IDLE, DECODE, RX_DATA, PAUSE, SEND_OS, SEND_WAIT, SEND_DATA, DONE.
REQ-022 Accepted start SHALL enter DECODE from any state (a new command supersedes the current message) and set busy the next cycle.
REQ-023 msg_err SHALL be set in DECODE if p_error was high with start, or SA == 0, SA == 31, or SA > NUM_SA; otherwise it SHALL be cleared.
REQ-024 Buffer index SHALL be {SA-1, word_cnt[4:0]}; word_cnt SHALL start at 0 and advance by 1 per word.
REQ-025 K == 0: DECODE -> RX_DATA; each rx_valid SHALL write rx_data to the buffer only if msg_err == 0, and OR p_error into msg_err.
REQ-026 RX_DATA SHALL move to PAUSE after N words.
REQ-027 RX_DATA SHALL return to IDLE with no response if RX_TIMEOUT cycles pass without rx_valid.
REQ-028 K == 1: DECODE -> PAUSE directly.
REQ-029 PAUSE SHALL last PAUSE_CYCLES cycles, then go to SEND_OS.
REQ-030 Broadcast SHALL skip the status word: PAUSE -> DONE.
REQ-031 SEND_OS SHALL drive tx_data = {ADDRESS, msg_err, 10'd0}, tx_cd = 1, tx_ready = 1 for one cycle.
REQ-032 After SEND_OS: K == 1 and msg_err == 0 -> SEND_WAIT; otherwise -> DONE.
REQ-033 SEND_WAIT SHALL issue the buffer read and wait for tx_busy == 0.
REQ-034 SEND_DATA SHALL drive the read word with tx_cd = 0 and a one-cycle tx_ready, then return to SEND_WAIT until N words are sent, then go to DONE.
REQ-035 DONE SHALL clear busy and go to IDLE next cycle.
REQ-036 tx_ready SHALL never assert while tx_busy == 1 in the same cycle.
REQ-037 Host port SHALL be independent of the FSM.
REQ-038 On a same-cycle, same-index write, the RT receive write SHALL win and the host write SHALL be dropped.
REQ-039 Host read of an index written in the same cycle SHALL return the old value.
REQ-040 rx_valid outside RX_DATA, and start with a non-matching address, SHALL have no effect.

Reset
REQ-041 While reset == 0 at a clk edge: STATE = IDLE; tx_data = 0; tx_cd = 0; tx_ready = 0; busy = 0; msg_err = 0; word_cnt = 0; timers = 0.
REQ-042 Buffer contents SHALL be unaffected by reset.
REQ-043 Reset asserted mid-message SHALL abort it with no further tx_ready.

Verification
REQ-044 Receive: host idle; start with 16'h0822, then rx_valid 16'hAAAA, 16'h5555 -> status 16'h0800, tx_cd = 1, PAUSE_CYCLES after last word; host reads index 0, 1 = 16'hAAAA, 16'h5555.
REQ-045 Transmit: host preloads SA2 words 0-2 = 1, 2, 3; start 16'h0C43 -> status 16'h0800, then data 1, 2, 3 with tx_cd = 0, each tx_ready only after tx_busy drops.
REQ-046 Errors: start 16'h0C43 with p_error = 1 -> only status 16'h0C00; start 16'h0C03 (SA 0) -> 16'h0C00, no data.
REQ-047 Broadcast/foreign: start 16'hF821 + one rx_valid -> word stored, no tx_ready; start 16'h1022 -> ignored, busy stays 0.
REQ-048 Abort/restart: start 16'h0822, one word then 64 idle cycles -> IDLE, no status; start 16'h0822 again mid-RX_DATA -> counter restarts at 0.
REQ-049 Reset and count 32: reset low during SEND_DATA -> all outputs 0 next cycle; start 16'h0C40 (N = 0) -> exactly 32 data words.
